// File: rtl/oflow_cr_lut_ctrl_if.sv
// Bus bundle for the conflict-resolve frame sequencer: the frame-controller
// handshake, the CR FSM handshake and LUT request, and the muxed LUT write port.
interface oflow_cr_lut_ctrl_if #(
  parameter int ADDR_WIDTH_LUT = 11,
  parameter int DATA_WIDTH_LUT = 16
);
  logic                      frame_start;
  logic                      frame_busy;
  logic                      frame_done;
  logic                      cr_timeout_err;
  logic [15:0]               cr_cycles;
  logic                      start_cr;
  logic                      done_cr;
  logic [ADDR_WIDTH_LUT-1:0] cr_address_lut;
  logic [DATA_WIDTH_LUT-1:0] cr_data_in_lut;
  logic                      cr_we_lut;
  logic [ADDR_WIDTH_LUT-1:0] lut_address;
  logic [DATA_WIDTH_LUT-1:0] lut_data_in;
  logic                      lut_we;

  // Environment side: drives requests and CR traffic, observes the sequencer.
  modport master (
    output frame_start, done_cr, cr_address_lut, cr_data_in_lut, cr_we_lut,
    input  frame_busy, frame_done, cr_timeout_err, cr_cycles, start_cr,
           lut_address, lut_data_in, lut_we
  );

  // Sequencer side.
  modport slave (
    input  frame_start, done_cr, cr_address_lut, cr_data_in_lut, cr_we_lut,
    output frame_busy, frame_done, cr_timeout_err, cr_cycles, start_cr,
           lut_address, lut_data_in, lut_we
  );
endinterface

// File: rtl/oflow_cr_lut_ctrl.sv
// Frame-level sequencer for the conflict-resolve stage: clears the ID LUT,
// kicks the conflict-resolve FSM, lends it the LUT write port until it reports
// done (or a cycle timeout fires) and reports completion and RUN-cycle count.
module oflow_cr_lut_ctrl #(
  parameter int ADDR_WIDTH_LUT = 11,
  parameter int DATA_WIDTH_LUT = 16,
  parameter int LUT_DEPTH      = 2048,
  parameter int CR_TIMEOUT     = 4096
) (
  input logic                clk,
  input logic                reset,
  oflow_cr_lut_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [ADDR_WIDTH_LUT-1:0] CLEAR_LAST  = ADDR_WIDTH_LUT'(LUT_DEPTH - 1);
  localparam logic [15:0]               RUN_LAST    = 16'(CR_TIMEOUT - 1);
  localparam logic [15:0]               TIMEOUT_VAL = 16'(CR_TIMEOUT);

  logic [2:0]                state_r;
  logic [2:0]                next_state_s;
  logic [ADDR_WIDTH_LUT-1:0] clear_addr_r;
  logic [15:0]               run_cnt_r;
  logic [15:0]               cr_cycles_r;
  logic                      timeout_err_r;
  logic                      clear_last_s;
  logic                      run_last_s;
  logic [ADDR_WIDTH_LUT-1:0] lut_address_s;
  logic [DATA_WIDTH_LUT-1:0] lut_data_in_s;
  logic                      lut_we_s;

  assign clear_last_s = (clear_addr_r == CLEAR_LAST);
  assign run_last_s   = (run_cnt_r == RUN_LAST);

  // Next-state selection; done_cr only matters in RUN, where it beats the timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.frame_start) next_state_s = ST_CLEAR;
        else                 next_state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clear_last_s) next_state_s = ST_START;
        else              next_state_s = ST_CLEAR;
      end
      ST_START: next_state_s = ST_RUN;
      ST_RUN: begin
        if (bus.done_cr || run_last_s) next_state_s = ST_DONE;
        else                           next_state_s = ST_RUN;
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register, clear address, RUN counter and the per-frame status latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      clear_addr_r  <= {ADDR_WIDTH_LUT{1'b0}};
      run_cnt_r     <= 16'd0;
      cr_cycles_r   <= 16'd0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.frame_start) begin
            clear_addr_r  <= {ADDR_WIDTH_LUT{1'b0}};
            timeout_err_r <= 1'b0;
          end
        end
        ST_CLEAR: clear_addr_r <= clear_addr_r + ADDR_WIDTH_LUT'(1'b1);
        ST_START: run_cnt_r <= 16'd0;
        ST_RUN: begin
          run_cnt_r <= run_cnt_r + 16'd1;
          if (bus.done_cr) begin
            cr_cycles_r <= run_cnt_r + 16'd1;
          end else if (run_last_s) begin
            cr_cycles_r   <= TIMEOUT_VAL;
            timeout_err_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // LUT write-port mux: zero-fill in CLEAR, CR FSM pass-through in START/RUN, idle otherwise.
  always_comb begin
    lut_address_s = {ADDR_WIDTH_LUT{1'b0}};
    lut_data_in_s = {DATA_WIDTH_LUT{1'b0}};
    lut_we_s      = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        lut_address_s = clear_addr_r;
        lut_data_in_s = {DATA_WIDTH_LUT{1'b0}};
        lut_we_s      = 1'b1;
      end
      ST_START, ST_RUN: begin
        lut_address_s = bus.cr_address_lut;
        lut_data_in_s = bus.cr_data_in_lut;
        lut_we_s      = bus.cr_we_lut;
      end
      default: begin
        lut_address_s = {ADDR_WIDTH_LUT{1'b0}};
        lut_data_in_s = {DATA_WIDTH_LUT{1'b0}};
        lut_we_s      = 1'b0;
      end
    endcase
  end

  assign bus.lut_address    = lut_address_s;
  assign bus.lut_data_in    = lut_data_in_s;
  assign bus.lut_we         = lut_we_s;
  assign bus.frame_busy     = (state_r != ST_IDLE);
  assign bus.frame_done     = (state_r == ST_DONE);
  assign bus.start_cr       = (state_r == ST_START);
  assign bus.cr_timeout_err = timeout_err_r;
  assign bus.cr_cycles      = cr_cycles_r;

endmodule

// File: tb/tb_oflow_cr_lut_ctrl.sv
// Directed bench for oflow_cr_lut_ctrl with LUT_DEPTH=8 and CR_TIMEOUT=16.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_oflow_cr_lut_ctrl;
  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic seen;

  oflow_cr_lut_ctrl_if #(.ADDR_WIDTH_LUT(AW), .DATA_WIDTH_LUT(DW)) bus ();

  oflow_cr_lut_ctrl #(
    .ADDR_WIDTH_LUT(AW),
    .DATA_WIDTH_LUT(DW),
    .LUT_DEPTH     (DEPTH),
    .CR_TIMEOUT    (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // {busy, done, err, start_cr, cr_cycles} and {we, address, data}
  logic [19:0] ctl;
  logic [27:0] port;
  assign ctl  = {bus.frame_busy, bus.frame_done, bus.cr_timeout_err, bus.start_cr, bus.cr_cycles};
  assign port = {bus.lut_we, bus.lut_address, bus.lut_data_in};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we);
    bus.cr_address_lut = a;
    bus.cr_data_in_lut = d;
    bus.cr_we_lut      = we;
  endtask

  initial begin
    reset           = 1'b1;
    bus.frame_start = 1'b0;
    bus.done_cr     = 1'b0;
    set_cr(11'h000, 16'h0000, 1'b0);

    // Reset held two cycles, then idle with CR inputs active (must be ignored)
    tick;
    check("rst_ctl", ctl, 20'h0);
    check("rst_port", port, 28'h0);
    tick;
    reset = 1'b0;
    set_cr(11'h123, 16'h00A5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("idle_ctl", ctl, 20'h0);
      check("idle_port", port, 28'h0);
    end

    // Nominal pass: frame_start at T; CR inputs driven during CLEAR are masked
    bus.frame_start = 1'b1;
    tick;                                     // T+1, CLEAR addr 0
    for (int i = 0; i < DEPTH; i++) begin
      check("clr_port", port, {1'b1, AW'(i), 16'h0000});
      check("clr_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
      bus.frame_start = (i == 4);             // collision in CLEAR is dropped
      tick;
    end
    // T+9: START, done_cr here must be ignored
    check("start_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 16'd0});
    check("start_port", port, {1'b1, 11'h123, 16'h00A5});
    bus.done_cr = 1'b1;
    tick;                                     // T+10, first RUN cycle
    bus.done_cr = 1'b0;
    check("run_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    check("run_port", port, {1'b1, 11'h123, 16'h00A5});
    set_cr(11'h7FF, 16'hFFFF, 1'b0);
    #1;
    check("run_port2", port, {1'b0, 11'h7FF, 16'hFFFF});
    tick;                                     // T+11
    tick;                                     // T+12
    bus.frame_start = 1'b1;                   // collision in RUN is dropped
    tick;                                     // T+13
    bus.frame_start = 1'b0;
    tick;                                     // T+14
    check("pre_done_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    bus.done_cr = 1'b1;
    set_cr(11'h055, 16'h1234, 1'b1);
    tick;                                     // T+15, DONE
    bus.done_cr = 1'b0;
    check("done_ctl", ctl, {1'b1, 1'b1, 1'b0, 1'b0, 16'd5});
    check("done_port", port, 28'h0);
    bus.frame_start = 1'b1;                   // dropped in DONE, held into IDLE
    tick;                                     // T+16, IDLE
    check("post_done_ctl", ctl, {1'b0, 1'b0, 1'b0, 1'b0, 16'd5});
    check("post_done_port", port, 28'h0);
    tick;                                     // accepted: CLEAR addr 0
    bus.frame_start = 1'b0;
    set_cr(11'h000, 16'h0000, 1'b0);
    check("accept_port", port, {1'b1, 11'd0, 16'h0000});

    // Timeout pass: done_cr never arrives
    repeat (DEPTH) tick;                      // START
    check("start2_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 16'd5});
    tick;                                     // R
    repeat (TMO - 1) tick;                    // R+15, last RUN cycle
    check("tmo_last_run", ctl, {1'b1, 1'b0, 1'b0, 1'b0, 16'd5});
    tick;                                     // R+16, DONE
    check("tmo_done", ctl, {1'b1, 1'b1, 1'b1, 1'b0, 16'd16});
    tick;
    check("tmo_sticky", ctl, {1'b0, 1'b0, 1'b1, 1'b0, 16'd16});
    tick;
    bus.frame_start = 1'b1;
    tick;                                     // CLEAR addr 0, error cleared
    bus.frame_start = 1'b0;
    check("err_clr", ctl, {1'b1, 1'b0, 1'b0, 1'b0, 16'd16});

    // done_cr coincides with the timeout cycle: no error
    repeat (DEPTH) tick;                      // START
    tick;                                     // R
    repeat (TMO - 1) tick;                    // R+15
    bus.done_cr = 1'b1;
    tick;                                     // DONE
    bus.done_cr = 1'b0;
    check("tie_done", ctl, {1'b1, 1'b1, 1'b0, 1'b0, 16'd16});
    tick;
    check("tie_idle", ctl, {1'b0, 1'b0, 1'b0, 1'b0, 16'd16});

    // Reset at CLEAR address 4, then a full restart from address 0
    bus.frame_start = 1'b1;
    tick;
    bus.frame_start = 1'b0;
    repeat (4) tick;
    check("pre_rst_port", port, {1'b1, 11'd4, 16'h0000});
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst_clr_ctl", ctl, 20'h0);
    check("rst_clr_port", port, 28'h0);
    bus.frame_start = 1'b1;
    tick;
    bus.frame_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("reclr_port", port, {1'b1, AW'(i), 16'h0000});
      tick;
    end
    check("restart_ctl", ctl, {1'b1, 1'b0, 1'b0, 1'b1, 16'd0});

    // Reset mid-RUN: no further start_cr or activity without a new frame
    tick;
    tick;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("rst_run_ctl", ctl, 20'h0);
    seen = 1'b0;
    repeat (30) begin
      tick;
      seen = seen | bus.start_cr | bus.frame_busy;
    end
    check("no_restart", {63'd0, seen}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/oflow_cr_lut_ctrl.md
Name: oflow_cr_lut_ctrl

Overview:
- Frame-level sequencer for the conflict-resolve stage.
- Per frame it zeroes the ID LUT, pulses start_cr to the conflict-resolve FSM, then gives that FSM the LUT write port until done_cr.
- Guards against a hung resolve with a cycle timeout; reports per-frame completion and cycle count.
- Sits between the core frame controller and the LUT/conflict-resolve FSM pair; the LUT read data goes straight to the FSM, not through this block.

Parameters:
- ADDR_WIDTH_LUT, 11: LUT address width.
- DATA_WIDTH_LUT, 16: LUT data width.
- LUT_DEPTH, 2048: number of LUT entries cleared per frame; must be ≤ 2^ADDR_WIDTH_LUT.
- CR_TIMEOUT, 4096: maximum RUN cycles before forced abort; must be ≤ 65535.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  request one conflict-resolve pass; accepted only in IDLE.
- frame_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the pass ends.
- cr_timeout_err  out  1  sticky; set on timeout abort, cleared when the next frame_start is accepted.
- cr_cycles  out  16  RUN-cycle count of the last pass, latched on exit from RUN.
- start_cr  out  1  one-cycle start pulse to the conflict-resolve FSM.
- done_cr  in  1  completion pulse from the conflict-resolve FSM.
- cr_address_lut  in  ADDR_WIDTH_LUT  FSM LUT address.
- cr_data_in_lut  in  DATA_WIDTH_LUT  FSM LUT write data.
- cr_we_lut  in  1  FSM LUT write enable.
- lut_address  out  ADDR_WIDTH_LUT  LUT address to the RAM.
- lut_data_in  out  DATA_WIDTH_LUT  LUT write data to the RAM.
- lut_we  out  1  LUT write enable to the RAM.

Behaviour:
- Reset: synchronous, active-high, takes priority over everything and can hit any state including mid-CLEAR or mid-RUN.
  - Forces IDLE; clear_addr=0, run_cnt=0, cr_cycles=0, cr_timeout_err=0.
  - All outputs read 0 in the cycle after reset is sampled.
  - A clear interrupted by reset is not resumed; the next accepted frame_start restarts it from address 0.
- States: IDLE, CLEAR, START, RUN, DONE.
- IDLE:
  - LUT outputs driven 0, lut_we=0; CR inputs are ignored.
  - frame_start=1 → go to CLEAR, clear_addr=0, cr_timeout_err=0.
- CLEAR:
  - lut_we=1, lut_address=clear_addr, lut_data_in=0.
  - clear_addr increments each cycle; when clear_addr==LUT_DEPTH-1 → START.
  - Exactly LUT_DEPTH write cycles, addresses 0..LUT_DEPTH-1 in order, no gaps.
  - cr_we_lut is gated off in this state; FSM requests are not stored or replayed.
- START:
  - start_cr=1 for exactly this one cycle; LUT port muxed to the CR inputs; run_cnt=0.
  - → RUN unconditionally; a done_cr seen in START is ignored.
- RUN:
  - LUT port is a combinational pass-through of the CR inputs (lut_address=cr_address_lut, lut_data_in=cr_data_in_lut, lut_we=cr_we_lut).
  - run_cnt increments each cycle.
  - done_cr=1 → DONE; cr_cycles=run_cnt+1.
  - Otherwise, run_cnt==CR_TIMEOUT-1 → DONE; cr_timeout_err=1; cr_cycles=CR_TIMEOUT.
  - If done_cr and timeout coincide, done_cr wins: no error is flagged.
- DONE:
  - frame_done=1 for one cycle; LUT port driven 0, lut_we=0.
  - → IDLE.
- frame_start outside IDLE is dropped, never queued. frame_start in the DONE cycle is also dropped; it is accepted in the following IDLE cycle if still held.
- done_cr outside RUN is ignored.
- Latency: frame_start accepted at cycle T gives CLEAR at T+1..T+LUT_DEPTH, START at T+LUT_DEPTH+1, RUN from T+LUT_DEPTH+2.
- Widths: run_cnt and cr_cycles are 16 bits and do not wrap, because CR_TIMEOUT ≤ 65535.

Test Plan:
- Reset then idle (LUT_DEPTH=8): hold reset 2 cycles, then frame_start=0 for 5 cycles → all outputs 0, frame_busy=0.
- Nominal pass (LUT_DEPTH=8): frame_start at T, done_cr at T+14 → lut_we=1 with addresses 0..7 and data 0 on T+1..T+8; start_cr only at T+9; frame_done at T+15; cr_cycles=5.
- Pass-through: in RUN drive cr_address_lut=0x123, cr_data_in_lut=0x00A5, cr_we_lut=1 → same values on the LUT port that cycle. The same drive during CLEAR → lut_data_in=0 and the clear address appear instead.
- Timeout (CR_TIMEOUT=16): done_cr never asserted → frame_done 16 cycles after the first RUN cycle; cr_timeout_err=1; cr_cycles=16. The next accepted frame_start clears the error.
- Collisions:
  - frame_start during CLEAR/RUN/DONE → no restart, clear addresses not reset.
  - done_cr during START → still enters RUN.
  - done_cr on the timeout cycle → cr_timeout_err=0.
- Reset mid-operation: reset at CLEAR address 4, then a new frame_start → clear restarts at address 0 and writes all 8 entries. Reset mid-RUN → start_cr is not re-pulsed until the next frame.
